// File: rtl/hdmi_pattern_gen_pkg.sv
// Shared definitions for the HDMI pattern generator: pattern codes, colours, box axis stepping.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package hdmi_pattern_gen_pkg;

    localparam int CNT_W = 12;

    localparam logic [2:0] PAT_BARS    = 3'd0;
    localparam logic [2:0] PAT_RAMP    = 3'd1;
    localparam logic [2:0] PAT_CHECKER = 3'd2;
    localparam logic [2:0] PAT_BOX     = 3'd3;
    localparam logic [2:0] PAT_SOLID   = 3'd4;

    localparam logic [23:0] WHITE = 24'hFF_FF_FF;
    localparam logic [23:0] BLACK = 24'h00_00_00;
    localparam logic [23:0] BLUE  = 24'h00_00_FF;

    // Element 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h00_00_00, 24'h00_00_FF, 24'hFF_00_00, 24'hFF_00_FF,
        24'h00_FF_00, 24'h00_FF_FF, 24'hFF_FF_00, 24'hFF_FF_FF
    };

    typedef struct packed {
        logic [CNT_W-1:0] pos;
        logic             neg;   // 1 = moving towards 0
    } axis_t;

    // One frame of bounce motion on a single axis, clamping at 0 and lim.
    function automatic axis_t axis_step(input axis_t cur, input logic [CNT_W-1:0] lim,
                                        input logic [CNT_W-1:0] step);
        axis_t          nxt;
        logic [CNT_W:0] up;
        nxt = cur;
        up  = {1'b0, cur.pos} + {1'b0, step};
        if (!cur.neg) begin
            if (up >= {1'b0, lim}) begin
                nxt.pos = lim;
                nxt.neg = 1'b1;
            end else begin
                nxt.pos = up[CNT_W-1:0];
            end
        end else begin
            if (cur.pos <= step) begin
                nxt.pos = '0;
                nxt.neg = 1'b0;
            end else begin
                nxt.pos = cur.pos - step;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pg_box_mover.sv
// Bouncing-box position tracker; advances both axes once per frame boundary.
// Latency: bx/by update 1 pclk after the fb pulse.
// Backpressure: none; fb is a single-cycle strobe.
module pg_box_mover
    import hdmi_pattern_gen_pkg::*;
#(
    parameter logic [CNT_W-1:0] X_LIM = 12'd1792,
    parameter logic [CNT_W-1:0] Y_LIM = 12'd952,
    parameter logic [CNT_W-1:0] STEP  = 12'd4
) (
    input  logic             pclk,
    input  logic             rst_,
    input  logic             fb,
    output logic [CNT_W-1:0] bx,
    output logic [CNT_W-1:0] by
);

    axis_t x_q, x_d;
    axis_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (fb) begin
            x_d = axis_step(x_q, X_LIM, STEP);
            y_d = axis_step(y_q, Y_LIM, STEP);
        end
    end

    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign bx = x_q.pos;
    assign by = y_q.pos;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel source feeding the TMDS encoder; moving box enabled by PATGEN_BOX_EN.
// Latency: exactly 2 pclk from raster inputs to RGB/hsync/vsync/vde.
// Backpressure: none; follows the timing generator every cycle.
module hdmi_pattern_gen
    import hdmi_pattern_gen_pkg::*;
#(
    parameter int HACT     = 1920,
    parameter int VACT     = 1080,
    parameter int BOX_SIZE = 128,
    parameter int BOX_STEP = 4
) (
    input  logic        pclk,
    input  logic        rst_,
    input  logic [11:0] hcount,
    input  logic [11:0] vcount,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [15:0] frame_cnt
);

    localparam int BAR_W = HACT / 8;

    logic        vblnk_q, vblnk_d;
    logic [2:0]  pat_q, pat_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        fb;
    logic        active;
    logic [2:0]  bar_idx;
    logic        box_hit;

    logic [23:0] s1_rgb_q, s1_rgb_d;
    logic        s1_act_q, s1_act_d;
    logic        s1_hs_q, s1_hs_d;
    logic        s1_vs_q, s1_vs_d;
    logic [23:0] rgb_q, rgb_d;
    logic        vde_q, vde_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    assign active = ~hblnk & ~vblnk;

    // Pattern and frame count only move on the rising edge of vblnk.
    always_comb begin
        vblnk_d     = vblnk;
        fb          = vblnk & ~vblnk_q;
        pat_d       = fb ? pat_sel : pat_q;
        frame_cnt_d = fb ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= CNT_W'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

`ifdef PATGEN_BOX_EN
    localparam logic [CNT_W:0] BOX_EXT = (CNT_W + 1)'(BOX_SIZE);

    logic [CNT_W-1:0] bx, by;

    pg_box_mover #(
        .X_LIM (CNT_W'(HACT - BOX_SIZE)),
        .Y_LIM (CNT_W'(VACT - BOX_SIZE)),
        .STEP  (CNT_W'(BOX_STEP))
    ) u_box_mover (
        .pclk (pclk),
        .rst_ (rst_),
        .fb   (fb),
        .bx   (bx),
        .by   (by)
    );

    assign box_hit = (hcount >= bx) && ({1'b0, hcount} < {1'b0, bx} + BOX_EXT) &&
                     (vcount >= by) && ({1'b0, vcount} < {1'b0, by} + BOX_EXT);
`else
    assign box_hit = 1'b0;
`endif

    always_comb begin
        s1_rgb_d = BLACK;
        case (pat_q)
            PAT_BARS:    s1_rgb_d = BAR_TABLE[bar_idx];
            PAT_RAMP:    s1_rgb_d = {3{hcount[10:3]}};
            PAT_CHECKER: s1_rgb_d = (hcount[6] ^ vcount[6]) ? WHITE : BLACK;
`ifdef PATGEN_BOX_EN
            PAT_BOX:     s1_rgb_d = box_hit ? WHITE : BLUE;
`endif
            PAT_SOLID:   s1_rgb_d = solid_rgb;
            default:     s1_rgb_d = BLACK;
        endcase
        s1_act_d = active;
        s1_hs_d  = hsync_in;
        s1_vs_d  = vsync_in;

        rgb_d = s1_act_q ? s1_rgb_q : BLACK;
        vde_d = s1_act_q;
        hs_d  = s1_hs_q;
        vs_d  = s1_vs_q;
    end

    // vblnk_q resets high so a release inside blanking does not fake a frame boundary.
    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            vblnk_q     <= 1'b1;
            pat_q       <= PAT_BARS;
            frame_cnt_q <= '0;
            s1_rgb_q    <= '0;
            s1_act_q    <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            rgb_q       <= '0;
            vde_q       <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            vblnk_q     <= vblnk_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_act_q    <= s1_act_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            rgb_q       <= rgb_d;
            vde_q       <= vde_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign red       = rgb_q[23:16];
    assign green     = rgb_q[15:8];
    assign blue      = rgb_q[7:0];
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign vde       = vde_q;
    assign frame_cnt = frame_cnt_q;

endmodule
